ctrl_pipe_hazard: RTL and testbench

- Consumes the decoded control bundle (WB, M, ALUOp, ALUSrc, RegDst) and register specifiers produced in ID.
- Carries the bundle through the ID/EX, EX/MEM and MEM/WB control registers of the SAD pipelined datapath.
- Detects load-use hazards and inserts bubbles; generates EX-stage forwarding selects.
- Flushes on taken branch/jump and keeps a saturating stall counter for SAD-loop profiling.

---
 rtl/ctrl_pipe_hazard.sv | 160 ++++++++++++++++
 tb/tb_ctrl_pipe_hazard.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard
// Control-side pipeline for the SAD datapath. Carries the decoded control
// bundle and register specifiers from ID through the ID/EX, EX/MEM and
// MEM/WB control registers. It also detects load-use hazards and inserts a
// single bubble for each one. It generates the EX-stage forwarding selects,
// flushes on a taken branch/jump, and keeps a saturating stall counter for
// loop profiling.
//
// Ports
//   Clk, Rst_n                      clock (rising edge), async active-low reset
//   ID_*                            decoded bundle and specifiers from ID
//   EX_BranchTaken                  branch/jump resolved taken in EX
//   EX_WB/M/ALUOp/ALUSrc/Rs/Rt      ID/EX register contents
//   EX_WriteReg                     EX destination (RegDst ? Rd : Rt)
//   MEM_WB, MEM_M, MEM_WriteReg     EX/MEM register contents
//   WB_WB, WB_WriteReg              MEM/WB register contents
//   ForwardA, ForwardB              00 regfile, 10 from MEM, 01 from WB
//   Stall, Flush                    hold PC + IF/ID / squash IF/ID
//   StallCount                      saturating count of stall cycles
module ctrl_pipe_hazard #(
    parameter int ALUOP_W = 5,
    parameter int M_W     = 5,
    parameter int WB_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               ID_Valid,
    input  logic [WB_W-1:0]    ID_WB,
    input  logic [M_W-1:0]     ID_M,
    input  logic [ALUOP_W-1:0] ID_ALUOp,
    input  logic               ID_ALUSrc,
    input  logic               ID_RegDst,
    input  logic [4:0]         ID_Rs,
    input  logic [4:0]         ID_Rt,
    input  logic [4:0]         ID_Rd,
    input  logic               EX_BranchTaken,
    output logic [WB_W-1:0]    EX_WB,
    output logic [M_W-1:0]     EX_M,
    output logic [ALUOP_W-1:0] EX_ALUOp,
    output logic               EX_ALUSrc,
    output logic [4:0]         EX_Rs,
    output logic [4:0]         EX_Rt,
    output logic [4:0]         EX_WriteReg,
    output logic [WB_W-1:0]    MEM_WB,
    output logic [M_W-1:0]     MEM_M,
    output logic [4:0]         MEM_WriteReg,
    output logic [WB_W-1:0]    WB_WB,
    output logic [4:0]         WB_WriteReg,
    output logic [1:0]         ForwardA,
    output logic [1:0]         ForwardB,
    output logic               Stall,
    output logic               Flush,
    output logic [CNT_W-1:0]   StallCount
);

    // RegDst and Rd are kept so the destination is resolved in EX. A bubble
    // zeroes both, which makes EX_WriteReg read as $0.
    logic       ex_regdst;
    logic [4:0] ex_rd;

    logic ex_load;
    logic id_uses_rt;
    logic hazard;
    logic load_bubble;

    assign EX_WriteReg = ex_regdst ? ex_rd : EX_Rt;

    assign ex_load    = (EX_M[1:0] != 2'b00) && EX_WB[1];
    assign id_uses_rt = ID_RegDst || (ID_M[3:2] != 2'b00) || ID_M[4];
    assign hazard     = ex_load && (EX_WriteReg != 5'd0) &&
                        ((EX_WriteReg == ID_Rs) ||
                         (id_uses_rt && (EX_WriteReg == ID_Rt)));

    // A taken branch squashes the ID instruction anyway, so a stall would
    // only waste a cycle and skew the profile counter.
    assign Stall       = ID_Valid && !EX_BranchTaken && hazard;
    assign Flush       = EX_BranchTaken;
    assign load_bubble = EX_BranchTaken || Stall || !ID_Valid;

    // MEM is checked first because it holds the newer value of the register.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       mem_wr,
        input logic [4:0] mem_reg,
        input logic       wb_wr,
        input logic [4:0] wb_reg
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_wr && (mem_reg != 5'd0) && (mem_reg == src)) begin
            sel = 2'b10;
        end else if (wb_wr && (wb_reg != 5'd0) && (wb_reg == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign ForwardA = fwd_sel(EX_Rs, MEM_WB[1], MEM_WriteReg, WB_WB[1], WB_WriteReg);
    assign ForwardB = fwd_sel(EX_Rt, MEM_WB[1], MEM_WriteReg, WB_WB[1], WB_WriteReg);

    // ID/EX: a bubble on flush, stall or an empty ID slot.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            EX_WB     <= '0;
            EX_M      <= '0;
            EX_ALUOp  <= '0;
            EX_ALUSrc <= 1'b0;
            EX_Rs     <= '0;
            EX_Rt     <= '0;
            ex_rd     <= '0;
            ex_regdst <= 1'b0;
        end else if (load_bubble) begin
            EX_WB     <= '0;
            EX_M      <= '0;
            EX_ALUOp  <= '0;
            EX_ALUSrc <= 1'b0;
            EX_Rs     <= '0;
            EX_Rt     <= '0;
            ex_rd     <= '0;
            ex_regdst <= 1'b0;
        end else begin
            EX_WB     <= ID_WB;
            EX_M      <= ID_M;
            EX_ALUOp  <= ID_ALUOp;
            EX_ALUSrc <= ID_ALUSrc;
            EX_Rs     <= ID_Rs;
            EX_Rt     <= ID_Rt;
            ex_rd     <= ID_Rd;
            ex_regdst <= ID_RegDst;
        end
    end

    // EX/MEM and MEM/WB always advance. The branch in EX moves on to MEM
    // untouched by its own flush.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            MEM_WB       <= '0;
            MEM_M        <= '0;
            MEM_WriteReg <= '0;
            WB_WB        <= '0;
            WB_WriteReg  <= '0;
        end else begin
            MEM_WB       <= EX_WB;
            MEM_M        <= EX_M;
            MEM_WriteReg <= EX_WriteReg;
            WB_WB        <= MEM_WB;
            WB_WriteReg  <= MEM_WriteReg;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            StallCount <= '0;
        end else if (Stall && (StallCount != {CNT_W{1'b1}})) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Testbench for ctrl_pipe_hazard. The counter is built 4 bits wide so that
// saturation can be reached quickly.
module tb_ctrl_pipe_hazard;

    logic       Clk;
    logic       Rst_n;
    logic       ID_Valid;
    logic [1:0] ID_WB;
    logic [4:0] ID_M;
    logic [4:0] ID_ALUOp;
    logic       ID_ALUSrc;
    logic       ID_RegDst;
    logic [4:0] ID_Rs, ID_Rt, ID_Rd;
    logic       EX_BranchTaken;
    logic [1:0] EX_WB;
    logic [4:0] EX_M;
    logic [4:0] EX_ALUOp;
    logic       EX_ALUSrc;
    logic [4:0] EX_Rs, EX_Rt, EX_WriteReg;
    logic [1:0] MEM_WB;
    logic [4:0] MEM_M;
    logic [4:0] MEM_WriteReg;
    logic [1:0] WB_WB;
    logic [4:0] WB_WriteReg;
    logic [1:0] ForwardA, ForwardB;
    logic       Stall, Flush;
    logic [3:0] StallCount;

    ctrl_pipe_hazard #(.ALUOP_W(5), .M_W(5), .WB_W(2), .CNT_W(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ID_Valid(ID_Valid), .ID_WB(ID_WB), .ID_M(ID_M), .ID_ALUOp(ID_ALUOp),
        .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
        .EX_BranchTaken(EX_BranchTaken),
        .EX_WB(EX_WB), .EX_M(EX_M), .EX_ALUOp(EX_ALUOp), .EX_ALUSrc(EX_ALUSrc),
        .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_WriteReg(EX_WriteReg),
        .MEM_WB(MEM_WB), .MEM_M(MEM_M), .MEM_WriteReg(MEM_WriteReg),
        .WB_WB(WB_WB), .WB_WriteReg(WB_WriteReg),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .Stall(Stall), .Flush(Flush), .StallCount(StallCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       valid;
        logic [1:0] wb;
        logic [4:0] m;
        logic [4:0] aluop;
        logic       alusrc;
        logic       regdst;
        logic [4:0] rs, rt, rd;
    } instr_t;

    typedef struct {
        instr_t     ins;
        logic       stall;
        logic [1:0] fa, fb;
        logic [4:0] exw, memw, wbw;
        logic [3:0] cnt;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic instr_t nop();
        return '{1'b0, 2'b00, 5'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0};
    endfunction
    function automatic instr_t rtype(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
        return '{1'b1, 2'b10, 5'b00000, op, 1'b0, 1'b1, rs, rt, rd};
    endfunction
    function automatic instr_t lw(input logic [4:0] rt, input logic [4:0] rs);
        return '{1'b1, 2'b10, 5'b00001, 5'd0, 1'b1, 1'b0, rs, rt, 5'd0};
    endfunction
    function automatic instr_t addi(input logic [4:0] rt, input logic [4:0] rs);
        return '{1'b1, 2'b10, 5'b00000, 5'd3, 1'b1, 1'b0, rs, rt, 5'd0};
    endfunction
    function automatic instr_t sw(input logic [4:0] rt, input logic [4:0] rs);
        return '{1'b1, 2'b00, 5'b01000, 5'd0, 1'b1, 1'b0, rs, rt, 5'd0};
    endfunction
    function automatic instr_t beq(input logic [4:0] rs, input logic [4:0] rt);
        return '{1'b1, 2'b00, 5'b10000, 5'd4, 1'b0, 1'b0, rs, rt, 5'd0};
    endfunction

    function automatic vec_t v(input instr_t i, input logic s, input logic [1:0] fa,
                               input logic [1:0] fb, input logic [4:0] exw,
                               input logic [4:0] memw, input logic [4:0] wbw,
                               input logic [3:0] cnt);
        vec_t r;
        r.ins = i; r.stall = s; r.fa = fa; r.fb = fb;
        r.exw = exw; r.memw = memw; r.wbw = wbw; r.cnt = cnt;
        return r;
    endfunction

    task automatic drive(input instr_t x);
        ID_Valid  = x.valid;
        ID_WB     = x.wb;
        ID_M      = x.m;
        ID_ALUOp  = x.aluop;
        ID_ALUSrc = x.alusrc;
        ID_RegDst = x.regdst;
        ID_Rs     = x.rs;
        ID_Rt     = x.rt;
        ID_Rd     = x.rd;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    vec_t tbl[23];

    initial begin
        // Each row: instruction placed in ID, then the expected outputs seen
        // before the following edge (state left by the earlier rows).
        tbl[0]  = v(lw(8, 1),          0, 2'b00, 2'b00, 0, 0, 0, 0);
        tbl[1]  = v(rtype(1, 9, 8, 10), 1, 2'b00, 2'b00, 8, 0, 0, 0);
        tbl[2]  = v(rtype(1, 9, 8, 10), 0, 2'b00, 2'b00, 0, 8, 0, 1);
        tbl[3]  = v(rtype(1, 3, 1, 2),  0, 2'b01, 2'b00, 9, 0, 8, 1);
        tbl[4]  = v(rtype(2, 4, 3, 3),  0, 2'b00, 2'b00, 3, 9, 0, 1);
        tbl[5]  = v(rtype(1, 5, 6, 7),  0, 2'b10, 2'b10, 4, 3, 9, 1);
        tbl[6]  = v(rtype(1, 3, 1, 2),  0, 2'b00, 2'b00, 5, 4, 3, 1);
        tbl[7]  = v(rtype(1, 5, 6, 7),  0, 2'b00, 2'b00, 3, 5, 4, 1);
        tbl[8]  = v(rtype(2, 4, 3, 3),  0, 2'b00, 2'b00, 5, 3, 5, 1);
        tbl[9]  = v(nop(),              0, 2'b01, 2'b01, 4, 5, 3, 1);
        tbl[10] = v(rtype(1, 3, 1, 2),  0, 2'b00, 2'b00, 0, 4, 5, 1);
        tbl[11] = v(rtype(1, 3, 1, 2),  0, 2'b00, 2'b00, 3, 0, 4, 1);
        tbl[12] = v(rtype(2, 4, 3, 3),  0, 2'b00, 2'b00, 3, 3, 0, 1);
        tbl[13] = v(nop(),              0, 2'b10, 2'b10, 4, 3, 3, 1);
        tbl[14] = v(lw(0, 1),           0, 2'b00, 2'b00, 0, 4, 3, 1);
        tbl[15] = v(rtype(1, 9, 0, 0),  0, 2'b00, 2'b00, 0, 0, 4, 1);
        tbl[16] = v(nop(),              0, 2'b00, 2'b00, 9, 0, 0, 1);
        tbl[17] = v(lw(8, 1),           0, 2'b00, 2'b00, 0, 9, 0, 1);
        tbl[18] = v(addi(8, 2),         0, 2'b00, 2'b00, 8, 0, 9, 1);
        tbl[19] = v(lw(8, 1),           0, 2'b00, 2'b10, 8, 8, 0, 1);
        tbl[20] = v(sw(8, 2),           1, 2'b00, 2'b10, 8, 8, 8, 1);
        tbl[21] = v(sw(8, 2),           0, 2'b00, 2'b00, 0, 8, 8, 2);
        tbl[22] = v(nop(),              0, 2'b00, 2'b01, 8, 0, 8, 2);

        Rst_n = 1'b0;
        EX_BranchTaken = 1'b0;
        drive(nop());
        step();
        step();
        chk("rst ex_wb", EX_WB, 0);
        chk("rst mem_wb", MEM_WB, 0);
        chk("rst wb_wb", WB_WB, 0);
        chk("rst stall", Stall, 0);
        chk("rst fwd_a", ForwardA, 0);
        chk("rst count", StallCount, 0);
        Rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].ins);
            #1;
            chk($sformatf("v%0d stall", i), Stall, tbl[i].stall);
            chk($sformatf("v%0d flush", i), Flush, 0);
            chk($sformatf("v%0d fwd_a", i), ForwardA, tbl[i].fa);
            chk($sformatf("v%0d fwd_b", i), ForwardB, tbl[i].fb);
            chk($sformatf("v%0d ex_wreg", i), EX_WriteReg, tbl[i].exw);
            chk($sformatf("v%0d mem_wreg", i), MEM_WriteReg, tbl[i].memw);
            chk($sformatf("v%0d wb_wreg", i), WB_WriteReg, tbl[i].wbw);
            chk($sformatf("v%0d count", i), StallCount, tbl[i].cnt);
            step();
        end

        // Taken branch while a load-use pair sits in ID/EX and ID.
        drive(lw(8, 1));
        step();
        drive(rtype(1, 9, 8, 10));
        EX_BranchTaken = 1'b1;
        #1;
        chk("br stall", Stall, 0);
        chk("br flush", Flush, 1);
        step();
        chk("br ex_wb", EX_WB, 0);
        chk("br ex_wreg", EX_WriteReg, 0);
        chk("br ex_aluop", EX_ALUOp, 0);
        chk("br mem_wreg", MEM_WriteReg, 8);
        chk("br mem_m", MEM_M, 5'b00001);
        chk("br count", StallCount, 2);

        // Branch bundle itself flows on into EX/MEM.
        EX_BranchTaken = 1'b0;
        drive(beq(1, 2));
        step();
        drive(rtype(1, 9, 8, 10));
        EX_BranchTaken = 1'b1;
        #1;
        chk("beq flush", Flush, 1);
        step();
        chk("beq mem_m", MEM_M, 5'b10000);
        chk("beq ex_wb", EX_WB, 0);
        chk("beq ex_rs", EX_Rs, 0);
        EX_BranchTaken = 1'b0;
        #1;
        chk("beq flush off", Flush, 0);

        // Asynchronous reset between edges with the pipe full.
        drive(rtype(1, 3, 1, 2));
        step();
        drive(rtype(1, 5, 6, 7));
        step();
        #2;
        Rst_n = 1'b0;
        #1;
        chk("arst ex_wb", EX_WB, 0);
        chk("arst ex_wreg", EX_WriteReg, 0);
        chk("arst mem_wb", MEM_WB, 0);
        chk("arst mem_wreg", MEM_WriteReg, 0);
        chk("arst wb_wb", WB_WB, 0);
        chk("arst count", StallCount, 0);
        chk("arst stall", Stall, 0);
        #1;
        Rst_n = 1'b1;
        drive(rtype(1, 3, 1, 2));
        step();
        drive(nop());
        chk("arst first ex", EX_WriteReg, 3);
        chk("arst wb0", WB_WB, 0);
        step();
        chk("arst wb1", WB_WB, 0);
        chk("arst mem1", MEM_WB, 2'b10);
        step();
        chk("arst wb2", WB_WB, 2'b10);
        chk("arst wb2 reg", WB_WriteReg, 3);

        // Twenty load-use pairs: counter climbs to 15 and holds.
        for (int i = 0; i < 20; i++) begin
            drive(lw(8, 1));
            step();
            drive(rtype(1, 9, 8, 10));
            #1;
            chk($sformatf("sat%0d stall", i), Stall, 1);
            step();
            chk($sformatf("sat%0d count", i), StallCount, (i + 1 > 15) ? 15 : i + 1);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
